// File: rtl/irq_controller_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_controller_unit_pkg                                       |
// | Purpose  : Shared constants, FSM state type and helper functions for     |
// |            the interrupt controller slice.                               |
// |            IO_IFLG / IO_IMSK : I/O-space addresses of the pending-flag   |
// |                                and mask registers.                       |
// |            irq_state_e       : request FSM states.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package irq_controller_unit_pkg;

  localparam logic [7:0] IO_IFLG = 8'h3A;
  localparam logic [7:0] IO_IMSK = 8'h3B;

  typedef enum logic [1:0] {
    IRQ_STATE_IDLE = 2'd0,
    IRQ_STATE_REQ  = 2'd1,
    IRQ_STATE_HOLD = 2'd2
  } irq_state_e;

  // Width of an index into n lines; a single line still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Untruncated vector for line idx; the caller truncates to its address width.
  function automatic int unsigned irq_vector_calc(input int unsigned base,
                                                  input int unsigned stride,
                                                  input int unsigned idx);
    return base + idx * stride;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_controller_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_controller_unit_if                                        |
// | Purpose  : CPU-side signal bundle of the interrupt controller.           |
// |            bus_addr          : CPU bus address                           |
// |            io_cs/io_we/io_oe : I/O select, write and read strobes        |
// |            sreg_i            : global interrupt enable (SREG I flag)     |
// |            ack               : one-cycle acknowledge from control unit   |
// |            irq / vector      : request and its program-memory target     |
// |            The tri-state data bus stays a plain inout on the top level.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface irq_controller_unit_if #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned I_ADDR_WIDTH = 10
);

  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic                    io_cs;
  logic                    io_we;
  logic                    io_oe;
  logic                    sreg_i;
  logic                    ack;
  logic                    irq;
  logic [I_ADDR_WIDTH-1:0] vector;

  // CPU / control-unit side
  modport master (
    output bus_addr, io_cs, io_we, io_oe, sreg_i, ack,
    input  irq, vector
  );

  // Interrupt controller side
  modport slave (
    input  bus_addr, io_cs, io_we, io_oe, sreg_i, ack,
    output irq, vector
  );

endinterface
`default_nettype wire

// File: rtl/irq_priority_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_priority_encoder                                          |
// | Purpose  : Combinational lowest-set-bit encoder (bit 0 wins).            |
// |            req   : request vector                                        |
// |            valid : any request bit set                                   |
// |            index : position of the lowest set bit (0 when none)          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module irq_priority_encoder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IDX_WIDTH = 3
) (
  input  wire logic [WIDTH-1:0]     req,
  output logic                      valid,
  output logic [IDX_WIDTH-1:0]      index
);

  // Scan from the top down so the last hit, the lowest set bit, sticks.
  always_comb begin
    valid = |req;
    index = '0;
    for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
      if (req[k]) begin
        index = IDX_WIDTH'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_controller_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : irq_controller_unit                                           |
// | Purpose  : Interrupt source block feeding the CPU control unit. Rising   |
// |            edges on irq_in set pending flags; pending & mask is          |
// |            arbitrated (bit 0 highest) and presented as irq + vector,     |
// |            held until a one-cycle ack. Pending (IFLG, W1C) and mask      |
// |            (IMSK, R/W) are mapped into I/O space.                        |
// | Ports    : clk      - system clock, rising edge                          |
// |            reset    - asynchronous, active-low reset                     |
// |            irq_in   - raw interrupt lines                                |
// |            bus      - irq_controller_unit_if.slave (address, strobes,    |
// |                       sreg_i, ack, irq, vector)                          |
// |            bus_data - tri-state CPU data bus                             |
// | Config   : IRQ_SYNC_EN - when defined, irq_in passes a two-flop          |
// |                          synchronizer before edge detection.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module irq_controller_unit
  import irq_controller_unit_pkg::*;
#(
  parameter int unsigned IRQ_COUNT     = 8,
  parameter int unsigned I_ADDR_WIDTH  = 10,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned VECTOR_BASE   = 1,
  parameter int unsigned VECTOR_STRIDE = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic [IRQ_COUNT-1:0]  irq_in,
  irq_controller_unit_if.slave       bus,
  inout  wire       [DATA_WIDTH-1:0] bus_data
);

  localparam int unsigned IDX_W = idx_width(IRQ_COUNT);

  // ---------------------------------------------------------------------
  // Input conditioning and edge detection
  // ---------------------------------------------------------------------
  logic [IRQ_COUNT-1:0] w_irq_src;
  logic [IRQ_COUNT-1:0] r_irq_in_q;
  logic [IRQ_COUNT-1:0] w_rise;

`ifdef IRQ_SYNC_EN
  logic [IRQ_COUNT-1:0] r_sync1;
  logic [IRQ_COUNT-1:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_src = r_sync2;
`else
  assign w_irq_src = irq_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_in_q <= '0;
    end else begin
      r_irq_in_q <= w_irq_src;
    end
  end

  assign w_rise = w_irq_src & ~r_irq_in_q;

  // ---------------------------------------------------------------------
  // I/O register decode
  // ---------------------------------------------------------------------
  logic                  w_hit_iflg;
  logic                  w_hit_imsk;
  logic                  w_wr;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [IRQ_COUNT-1:0]  w_wdata;
  logic [IRQ_COUNT-1:0]  w_w1c;
  logic                  w_unused_data;

  logic [IRQ_COUNT-1:0]  r_pending;
  logic [IRQ_COUNT-1:0]  r_imsk;

  assign w_hit_iflg = (bus.bus_addr == ADDR_WIDTH'(IO_IFLG));
  assign w_hit_imsk = (bus.bus_addr == ADDR_WIDTH'(IO_IMSK));
  assign w_wr       = bus.io_cs && bus.io_we;
  assign w_rd_en    = bus.io_cs && bus.io_oe && !bus.io_we && (w_hit_iflg || w_hit_imsk);

  // Register bits at IRQ_COUNT and above do not exist: they read 0 and
  // their write data is dropped.
  assign w_wdata       = bus_data[IRQ_COUNT-1:0];
  assign w_unused_data = &{1'b0, bus_data};
  assign w_w1c         = (w_wr && w_hit_iflg) ? w_wdata : '0;

  assign w_rd_data = w_hit_iflg ? DATA_WIDTH'(r_pending) : DATA_WIDTH'(r_imsk);
  assign bus_data  = w_rd_en ? w_rd_data : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_imsk <= '0;
    end else if (w_wr && w_hit_imsk) begin
      r_imsk <= w_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [IRQ_COUNT-1:0] w_active;
  logic                 w_valid;
  logic [IDX_W-1:0]     w_index;

  assign w_active = r_pending & r_imsk;

  irq_priority_encoder #(
    .WIDTH     (IRQ_COUNT),
    .IDX_WIDTH (IDX_W)
  ) u_prio (
    .req   (w_active),
    .valid (w_valid),
    .index (w_index)
  );

  // ---------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------
  irq_state_e r_state;
  irq_state_e w_state_next;
  logic       w_load;
  logic       w_ack_take;
  logic       w_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IRQ_STATE_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Once in REQ the request is never withdrawn: only ack leaves the state,
  // regardless of sreg_i, mask writes or software clears.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ack_take   = 1'b0;
    w_irq        = 1'b0;
    case (r_state)
      IRQ_STATE_IDLE: begin
        if (bus.sreg_i && w_valid) begin
          w_load       = 1'b1;
          w_state_next = IRQ_STATE_REQ;
        end
      end
      IRQ_STATE_REQ: begin
        w_irq = 1'b1;
        if (bus.ack) begin
          w_ack_take   = 1'b1;
          w_state_next = IRQ_STATE_HOLD;
        end
      end
      // One quiet cycle lets the control unit's cleared I flag arrive
      // before arbitration runs again.
      IRQ_STATE_HOLD: begin
        w_state_next = IRQ_STATE_IDLE;
      end
      default: begin
        w_state_next = IRQ_STATE_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Selected line, vector and pending flags
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]        r_sel;
  logic [I_ADDR_WIDTH-1:0] r_vector;
  logic [I_ADDR_WIDTH-1:0] w_vector_next;
  logic [IRQ_COUNT-1:0]    w_ack_clr;
  logic [IRQ_COUNT-1:0]    w_pending_next;

  assign w_vector_next = I_ADDR_WIDTH'(irq_vector_calc(VECTOR_BASE, VECTOR_STRIDE, 32'(w_index)));
  assign w_ack_clr     = w_ack_take ? (IRQ_COUNT'(1) << r_sel) : '0;

  // Clears are applied first so a fresh edge on the same bit survives.
  assign w_pending_next = (r_pending & ~w_w1c & ~w_ack_clr) | w_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel     <= '0;
      r_vector  <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_load) begin
        r_sel    <= w_index;
        r_vector <= w_vector_next;
      end
    end
  end

  assign bus.irq    = w_irq;
  assign bus.vector = r_vector;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_irq_controller_unit                                        |
// | Purpose  : Self-checking bench for irq_controller_unit: directed steps   |
// |            followed by random traffic, all compared against a            |
// |            behavioural model of pending flags, mask and request state.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_irq_controller_unit;

  localparam int unsigned NIRQ = 8;
  localparam int unsigned IAW  = 10;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned VB   = 1;
  localparam int unsigned VS   = 1;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    irq_in;
  wire  [DW-1:0] bus_data;
  logic          tb_drv;
  logic [7:0]    tb_data;

  irq_controller_unit_if #(.ADDR_WIDTH(AW), .I_ADDR_WIDTH(IAW)) bus_if ();

  irq_controller_unit #(
    .IRQ_COUNT     (NIRQ),
    .I_ADDR_WIDTH  (IAW),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .VECTOR_BASE   (VB),
    .VECTOR_STRIDE (VS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .bus      (bus_if),
    .bus_data (bus_data)
  );

  assign bus_data = tb_drv ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_pending, m_imsk, m_prev, m_s1, m_s2;
  bit         m_req, m_hold;
  int         m_sel, m_vec;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = '0; m_imsk = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    m_req = 1'b0; m_hold = 1'b0; m_sel = 0; m_vec = 0;
  endtask

  // One clock: predict the post-edge state from the current inputs, take the
  // edge, then compare irq/vector with the prediction.
  task automatic tick();
    logic [7:0] rise, w1c, aclr, act, nimsk, npend;
    bit         nreq, nhold;
    int         nsel, nvec;
`ifdef IRQ_SYNC_EN
    rise = m_s2 & ~m_prev;
`else
    rise = irq_in & ~m_prev;
`endif
    w1c = '0; nimsk = m_imsk; aclr = '0;
    if (bus_if.io_cs && bus_if.io_we && tb_drv) begin
      if (bus_if.bus_addr == 16'h003A) w1c = tb_data;
      if (bus_if.bus_addr == 16'h003B) nimsk = tb_data;
    end
    act = m_pending & m_imsk;
    nreq = m_req; nhold = m_hold; nsel = m_sel; nvec = m_vec;
    if (m_req) begin
      if (bus_if.ack) begin
        aclr[m_sel] = 1'b1;
        nreq = 1'b0;
        nhold = 1'b1;
      end
    end else if (m_hold) begin
      nhold = 1'b0;
    end else if (bus_if.sreg_i && act != 0) begin
      for (int k = 7; k >= 0; k--) if (act[k]) nsel = k;
      nreq = 1'b1;
      nvec = (VB + nsel * VS) % (1 << IAW);
    end
    npend = (m_pending & ~w1c & ~aclr) | rise;

    @(posedge clk);
    #1;
    m_pending = npend; m_imsk = nimsk; m_req = nreq; m_hold = nhold;
    m_sel = nsel; m_vec = nvec;
`ifdef IRQ_SYNC_EN
    m_prev = m_s2; m_s2 = m_s1; m_s1 = irq_in;
`else
    m_prev = irq_in;
`endif
    if (!reset) model_reset();
    check("irq", 32'(bus_if.irq), 32'(m_req));
    check("vector", 32'(bus_if.vector), 32'(m_vec));
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    bus_if.bus_addr = addr; bus_if.io_cs = 1'b1; bus_if.io_we = 1'b1;
    tb_drv = 1'b1; tb_data = data;
    tick();
    bus_if.io_cs = 1'b0; bus_if.io_we = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus_if.bus_addr = addr; bus_if.io_cs = 1'b1; bus_if.io_oe = 1'b1; bus_if.io_we = 1'b0;
    #1;
    check(tag, 32'(bus_data), 32'(exp));
    bus_if.io_cs = 1'b0; bus_if.io_oe = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int exp_lat);
    int n = 0;
    while (!bus_if.irq && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    logic [7:0] tg;
    int         op;

    reset = 1'b0; irq_in = '0; tb_drv = 1'b0; tb_data = '0;
    bus_if.bus_addr = '0; bus_if.io_cs = 1'b0; bus_if.io_we = 1'b0; bus_if.io_oe = 1'b0;
    bus_if.sreg_i = 1'b0; bus_if.ack = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_irq", 32'(bus_if.irq), 32'd0);
    check("rst_vector", 32'(bus_if.vector), 32'd0);
    bus_read("rst_iflg", 16'h003A, 8'h00);
    bus_read("rst_imsk", 16'h003B, 8'h00);
    reset = 1'b1;
    tick();

    // Single line, mask bit 0
    bus_write(16'h003B, 8'h01);
    bus_if.sreg_i = 1'b1;
    irq_in = 8'h01;
    wait_irq("t1_latency", LAT);
    check("t1_vector", 32'(bus_if.vector), 32'd1);
    irq_in = 8'h00;
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
    check("t1_irq_after_ack", 32'(bus_if.irq), 32'd0);
    bus_read("t1_iflg", 16'h003A, 8'h00);
    tick();

    // Two simultaneous edges: line 2 first, then line 5
    bus_write(16'h003B, 8'hFF);
    irq_in = 8'h24; tick(); irq_in = 8'h00;
    wait_irq("t2_latency", LAT - 1);
    check("t2_vector_a", 32'(bus_if.vector), 32'd3);
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
    check("t2_hold_irq", 32'(bus_if.irq), 32'd0);
    tick();
    check("t2_idle_irq", 32'(bus_if.irq), 32'd0);
    tick();
    check("t2_irq_b", 32'(bus_if.irq), 32'd1);
    check("t2_vector_b", 32'(bus_if.vector), 32'd6);
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
    tick();

    // Global enable gates the request
    bus_if.sreg_i = 1'b0;
    irq_in = 8'h08;
    repeat (LAT + 2) tick();
    irq_in = 8'h00;
    check("t3_irq_gated", 32'(bus_if.irq), 32'd0);
    bus_read("t3_iflg", 16'h003A, 8'h08);
    bus_if.sreg_i = 1'b1;
    tick();
    check("t3_irq", 32'(bus_if.irq), 32'd1);
    check("t3_vector", 32'(bus_if.vector), 32'd4);

    // No withdrawal while requesting
    bus_if.sreg_i = 1'b0;
    bus_write(16'h003B, 8'h00);
    tick();
    check("t4_irq_held", 32'(bus_if.irq), 32'd1);
    check("t4_vector_held", 32'(bus_if.vector), 32'd4);
    bus_read("t4_imsk", 16'h003B, 8'h00);
    bus_if.ack = 1'b1; tick(); bus_if.ack = 1'b0;
    repeat (3) tick();
    check("t4_irq_released", 32'(bus_if.irq), 32'd0);
    bus_if.sreg_i = 1'b1;

    // W1C against a same-edge set
    irq_in = 8'h04;
    repeat (LAT) tick();
    irq_in = 8'h00;
    repeat (3) tick();
    bus_read("t5_iflg_set", 16'h003A, 8'h04);
    irq_in = 8'h04;
    repeat (LAT - 2) tick();
    bus_write(16'h003A, 8'h04);
    bus_read("t5_set_wins", 16'h003A, 8'h04);
    irq_in = 8'h00;
    repeat (3) tick();
    bus_write(16'h003A, 8'h04);
    bus_read("t5_cleared", 16'h003A, 8'h00);

    // Reset in the middle of a request
    bus_write(16'h003B, 8'h01);
    irq_in = 8'h01;
    wait_irq("t6_latency", LAT);
    irq_in = 8'h00;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("t6_irq_reset", 32'(bus_if.irq), 32'd0);
    check("t6_vector_reset", 32'(bus_if.vector), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    bus_read("t6_iflg", 16'h003A, 8'h00);
    bus_read("t6_imsk", 16'h003B, 8'h00);
    tick();

    // Random traffic against the model
    bus_write(16'h003B, 8'($urandom));
    for (int it = 0; it < 400; it++) begin
      for (int b = 0; b < 8; b++) tg[b] = ($urandom_range(0, 7) == 0);
      irq_in = irq_in ^ tg;
      if ($urandom_range(0, 9) == 0) bus_if.sreg_i = ~bus_if.sreg_i;
      bus_if.ack = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
      op = int'($urandom_range(0, 15));
      case (op)
        0: bus_write(16'h003B, 8'($urandom));
        1: bus_write(16'h003A, 8'($urandom));
        2: begin bus_read("rnd_iflg", 16'h003A, m_pending); tick(); end
        3: begin bus_read("rnd_imsk", 16'h003B, m_imsk); tick(); end
        default: tick();
      endcase
      bus_if.ack = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
